// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: op codes,
// FSM encodings and default HI/LO bus widths.
package muldiv_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_ITER = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  typedef logic [MD_XLEN-1:0]   md_word_t;
  typedef logic [2*MD_XLEN-1:0] md_dword_t;

  // Only MULT and DIV treat their operands as two's complement.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate. Gives |x| on operand latch and
// restores the result sign in the FIX step.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Negate when asked, pass through otherwise.
  assign res_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide unit owning the HI/LO register pair.
//
//   state   | meaning
//   IDLE    | waiting for start; MTHI/MTLO write HI/LO directly
//   ITER    | one shift-add (MUL) or restoring (DIV) step per cycle
//   FIX     | sign correction, HI/LO write, done pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   acc_q, acc_step;
  logic [XLEN-1:0]     opnd_q, hi_q, lo_q;
  logic                is_div_q, neg_res_q, neg_rem_q, bzero_q, divz_q;

  logic                op_valid, op_muldiv, op_signed, accept;
  logic                neg_res_in, neg_rem_in;
  logic [XLEN-1:0]     a_mag, b_mag, quo_fix, rem_fix;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN:0]       mul_sum, div_tmp, div_diff;

  assign op_valid   = (op <= MD_MTLO);
  assign op_muldiv  = (op <= MD_DIVU);
  assign op_signed  = md_is_signed(op);
  assign accept     = start && !flush && (state_q == MD_IDLE) && op_valid;
  assign neg_res_in = op_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
  assign neg_rem_in = op_signed & op_a[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.val_i(op_a), .neg_i(op_signed & op_a[XLEN-1]), .res_o(a_mag));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.val_i(op_b), .neg_i(op_signed & op_b[XLEN-1]), .res_o(b_mag));
  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.val_i(acc_q), .neg_i(neg_res_q), .res_o(prod_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_quo (.val_i(acc_q[XLEN-1:0]), .neg_i(neg_res_q), .res_o(quo_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_rem (.val_i(acc_q[2*XLEN-1:XLEN]), .neg_i(neg_rem_q), .res_o(rem_fix));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always lands in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept && op_muldiv) state_d = MD_ITER;
      MD_ITER: begin
        if (flush)                               state_d = MD_IDLE;
        else if (cnt_q == CNT_W'(1))             state_d = MD_FIX;
      end
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Status outputs; a flushed FIX cycle does not count as done.
  always_comb begin
    busy = (state_q != MD_IDLE);
    done = (state_q == MD_FIX) && !flush;
  end

  // One iteration step: shift-add for MUL, restoring subtract for DIV.
  // A zero divisor leaves the shifted-in dividend bits as the remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opnd_q};
    div_tmp  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_tmp - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_diff[XLEN]) acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_step = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Datapath registers: operand latch, iteration, HI/LO and sticky div-by-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            divz_q <= 1'b0;
            if (op == MD_MTHI) hi_q <= op_a;
            if (op == MD_MTLO) lo_q <= op_a;
            if (op_muldiv) begin
              is_div_q  <= (op == MD_DIV) || (op == MD_DIVU);
              neg_res_q <= neg_res_in;
              neg_rem_q <= neg_rem_in;
              bzero_q   <= (op_b == '0);
              cnt_q     <= CNT_W'(XLEN);
              if ((op == MD_DIV) || (op == MD_DIVU)) begin
                acc_q  <= {{XLEN{1'b0}}, a_mag};
                opnd_q <= b_mag;
              end else begin
                acc_q  <= {{XLEN{1'b0}}, b_mag};
                opnd_q <= a_mag;
              end
            end
          end
        end
        MD_ITER: begin
          if (flush) begin
            cnt_q <= '0;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        MD_FIX: begin
          if (!flush) begin
            if (is_div_q) begin
              hi_q   <= rem_fix;
              lo_q   <= bzero_q ? {XLEN{1'b1}} : quo_fix;
              divz_q <= bzero_q;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign div_zero = divz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes reference results,
// a monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi_o, lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference results straight from the arithmetic definition.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic d);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = '0; l = '0; d = 1'b0;
    case (o)
      MD_MULT:  begin q = sa * sb; p = q; h = p[63:32]; l = p[31:0]; end
      MD_MULTU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      MD_DIV, MD_DIVU: begin
        if (b == 0) begin
          l = '1; h = a; d = 1'b1;
        end else if (o == MD_DIV) begin
          q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0];
        end else begin
          p = ua / ub; l = p[31:0];
          p = ua % ub; h = p[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", busy, 0);
  endtask

  // Issue one op; mul/div results go to the scoreboard, MT* and reserved are checked here.
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] h, l;
    logic d;
    wait_idle();
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (o <= MD_DIVU) begin
      model(o, a, b, h, l, d);
      e.hi = h; e.lo = l; e.dz = d; e.acc_cyc = cyc; e.name = name;
      exp_q.push_back(e);
      m_hi = h; m_lo = l;
      check({name, "_busy"}, busy, 1);
      check({name, "_dz_clear"}, div_zero, 0);
    end else if (o <= MD_MTLO) begin
      if (o == MD_MTHI) m_hi = a; else m_lo = a;
      check({name, "_hi"}, hi_o, m_hi);
      check({name, "_lo"}, lo_o, m_lo);
      check({name, "_busy"}, busy, 0);
      check({name, "_dz_clear"}, div_zero, 0);
    end else begin
      check({name, "_busy"}, busy, 0);
      check({name, "_hi"}, hi_o, m_hi);
      check({name, "_lo"}, lo_o, m_lo);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_with_no_pending_op", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          @(posedge clk); #1;
          check({e.name, "_hi"}, hi_o, e.hi);
          check({e.name, "_lo"}, lo_o, e.lo);
          check({e.name, "_div_zero"}, div_zero, e.dz);
          check({e.name, "_latency"}, cyc - e.acc_cyc, XLEN + 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7);
    issue("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    issue("divu_zero", MD_DIVU, 32'd100, 32'd0);
    issue("multu_after_dz", MD_MULTU, 32'd3, 32'd5);
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("div_zero_signed", MD_DIV, 32'hFFFF_FF00, 32'd0);

    // Flush mid-iteration.
    wait_idle();
    start = 1'b1; op = MD_DIV; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_iter_busy", busy, 0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_iter_hi", hi_o, m_hi);
    check("flush_iter_lo", lo_o, m_lo);

    // Flush during FIX suppresses the write and the div_zero flag.
    start = 1'b1; op = MD_DIVU; op_a = 32'd55; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (XLEN) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    check("flush_fix_in_fix", busy, 1);
    check("flush_fix_done", done, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_fix_busy", busy, 0);
    check("flush_fix_hi", hi_o, m_hi);
    check("flush_fix_lo", lo_o, m_lo);
    check("flush_fix_div_zero", div_zero, 0);

    // start together with flush in IDLE is dropped.
    start = 1'b1; flush = 1'b1; op = MD_MTHI; op_a = 32'hDEAD;
    @(posedge clk); #1;
    check("startflush_mthi", hi_o, m_hi);
    op = MD_MULT; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("startflush_mult_busy", busy, 0);

    // Back-to-back MTHI / MTLO, then a reserved op.
    issue("mthi", MD_MTHI, 32'h1234, 32'd0);
    issue("mtlo", MD_MTLO, 32'h5678, 32'd0);
    issue("reserved6", 3'd6, 32'hAAAA, 32'hBBBB);

    // A start while busy is ignored.
    issue("multu_busy", MD_MULTU, 32'h0123_4567, 32'h089A_BCDE);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = MD_DIV; op_a = 32'd77; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start_busy", busy, 1);

    // Asynchronous reset mid-DIV.
    issue("mthi_pre_rst", MD_MTHI, 32'hCAFE, 32'd0);
    issue("div_rst", MD_DIV, 32'd12345, 32'd17);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_div_zero", div_zero, 0);
    check("midrst_hi", hi_o, 0);
    check("midrst_lo", lo_o, 0);
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue("multu_6x7", MD_MULTU, 32'd6, 32'd7);

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      issue($sformatf("rnd%0d", i), 3'($urandom_range(0, 5)), pick(), pick());
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
